iter_divider: RTL and testbench

Parametrised iterative integer divider for the RISC5 execute stage, generalising the fixed 32-bit divide unit. It computes quotient and remainder for signed or unsigned operands of width W, one quotient bit per enabled clock. It stalls the core through the standard combinational `run`/`stall` pair and honours the core clock enable. It adds a divide-by-zero flag with an early exit and selectable remainder convention.

---
 rtl/iter_divider.sv | 147 ++++++++++++++
 tb/tb_iter_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Iterative restoring divider, one quotient bit per enabled clock.
// Define DIV_FLOOR_EN for Euclidean signed results (0 <= rem < |y|).
module iter_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         run,
    input  logic         sgn,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         stall,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         dz
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  pr_q, pr_d;
    logic          sx_q, sx_d, sy_q, sy_d, sgn_q, sgn_d;
    logic [W-1:0]  quot_q, quot_d, rem_q, rem_d;
    logic          dz_q, dz_d;

    logic [W:0]    sh, diff;
    logic          qbit;
    logic [W-1:0]  pr_nxt, q_nxt;
    logic [W-1:0]  qs, rs;
    logic [W-1:0]  xmag, ymag;

    assign xmag = (sgn && x[W-1]) ? (~x + 1'b1) : x;
    assign ymag = (sgn && y[W-1]) ? (~y + 1'b1) : y;

    // one restoring step: W+1-bit trial subtract, borrow means restore
    always_comb begin
        sh     = {pr_q, dvd_q[W-1]};
        diff   = sh - {1'b0, dvs_q};
        qbit   = ~diff[W];
        pr_nxt = qbit ? diff[W-1:0] : sh[W-1:0];
        q_nxt  = {dvd_q[W-2:0], qbit};
    end

    always_comb begin
        qs = q_nxt;
        rs = pr_nxt;
        if (sgn_q) begin
            qs = (sx_q ^ sy_q) ? (~q_nxt + 1'b1) : q_nxt;
            rs = sx_q ? (~pr_nxt + 1'b1) : pr_nxt;
`ifdef DIV_FLOOR_EN
            if (sx_q && (pr_nxt != '0)) begin
                rs = dvs_q - pr_nxt;
                qs = sy_q ? (qs + 1'b1) : (qs - 1'b1);
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        sgn_d   = sgn_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        dvd_d = xmag;
                        dvs_d = ymag;
                        sx_d  = sgn & x[W-1];
                        sy_d  = sgn & y[W-1];
                        sgn_d = sgn;
                        pr_d  = '0;
                        cnt_d = CW'(W);
                        if (y == '0) begin
                            quot_d  = '1;
                            rem_d   = x;
                            dz_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            dz_d    = 1'b0;
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    dvd_d = q_nxt;
                    pr_d  = pr_nxt;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        quot_d  = qs;
                        rem_d   = rs;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            sgn_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sgn_q   <= sgn_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign stall = run & (state_q != DONE);
    assign quot  = quot_q;
    assign rem   = rem_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider (W=32): vector table plus
// hand-written back-to-back, clock-enable, run-drop and reset sequences.
module tb_iter_divider;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        run;
    logic        sgn;
    logic [31:0] x, y;
    logic        stall;
    logic [31:0] quot, rem;
    logic        dz;

    int n_pass = 0;
    int n_tot  = 0;

    iter_divider #(.W(32)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .ce    (ce),
        .run   (run),
        .sgn   (sgn),
        .x     (x),
        .y     (y),
        .stall (stall),
        .quot  (quot),
        .rem   (rem),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] x;
        logic [31:0] y;
        int          cyc;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // count stall cycles from the current cycle until stall drops
    task automatic wait_done(output int n);
        n = 0;
        while (stall && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    int n;

    initial begin
        tv[0]  = '{1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0};
`ifdef DIV_FLOOR_EN
        tv[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFC, 32'd1, 1'b0};
`else
        tv[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
`endif
        tv[2]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1, 1'b0};
        tv[3]  = '{1'b1, 32'h12345678, 32'd0, 1, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        tv[4]  = '{1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0};
        tv[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0, 1'b0};
        tv[6]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 33, 32'hFFFFFFFF, 32'd0, 1'b0};
        tv[7]  = '{1'b0, 32'd5, 32'd10, 33, 32'd0, 32'd5, 1'b0};
`ifdef DIV_FLOOR_EN
        tv[8]  = '{1'b1, 32'hFFFFFF9C, 32'd7, 33, 32'hFFFFFFF1, 32'd5, 1'b0};
        tv[11] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 33, 32'd1, 32'h7FFFFFFF, 1'b0};
`else
        tv[8]  = '{1'b1, 32'hFFFFFF9C, 32'd7, 33, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        tv[11] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 33, 32'd0, 32'hFFFFFFFF, 1'b0};
`endif
        tv[9]  = '{1'b1, 32'd100, 32'hFFFFFFF9, 33, 32'hFFFFFFF2, 32'd2, 1'b0};
        tv[10] = '{1'b0, 32'd0, 32'd0, 1, 32'hFFFFFFFF, 32'd0, 1'b1};

        rst_n = 1'b0;
        ce    = 1'b1;
        run   = 1'b1;
        sgn   = 1'b0;
        x     = '0;
        y     = '0;
        #12;
        chk("reset_quot", quot, 32'd0);
        chk("reset_rem", rem, 32'd0);
        chk("reset_dz", {31'd0, dz}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd1);
        run   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            sgn = tv[i].s;
            x   = tv[i].x;
            y   = tv[i].y;
            run = 1'b1;
            #1;
            @(posedge clk);
            #1;
            x = 32'hDEADBEEF;
            y = 32'h00000003;
            sgn = ~tv[i].s;
            n = 1;
            if (stall) begin
                int m;
                wait_done(m);
                n = n + m;
            end
            chk($sformatf("v%0d_cycles", i), n, tv[i].cyc);
            chk($sformatf("v%0d_quot", i), quot, tv[i].q);
            chk($sformatf("v%0d_rem", i), rem, tv[i].r);
            chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, tv[i].dz});
            run = 1'b0;
            @(posedge clk);
            #1;
        end

        // back-to-back with run held high
        sgn = 1'b0;
        x   = 32'd40;
        y   = 32'd6;
        run = 1'b1;
        #1;
        wait_done(n);
        chk("b2b_first_cycles", n, 33);
        chk("b2b_first_quot", quot, 32'd6);
        chk("b2b_first_rem", rem, 32'd4);
        x = 32'hFFFFFFFF;
        y = 32'd16;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (stall && n < 300);
        chk("b2b_second_cycles", n, 34);
        chk("b2b_second_quot", quot, 32'h0FFFFFFF);
        chk("b2b_second_rem", rem, 32'd15);
        run = 1'b0;
        @(posedge clk);
        #1;

        // clock enable active one cycle in three
        x   = 32'd100;
        y   = 32'd7;
        run = 1'b1;
        n   = 0;
        ce  = 1'b0;
        #1;
        while (stall && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            ce = (n % 3 == 2);
        end
        chk("ce_cycles", n, 99);
        chk("ce_quot", quot, 32'd14);
        chk("ce_rem", rem, 32'd2);
        ce  = 1'b1;
        run = 1'b0;
        @(posedge clk);
        #1;

        // run dropped mid-operation: result still loaded internally
        x   = 32'd1000;
        y   = 32'd10;
        run = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run = 1'b0;
        #1;
        chk("rundrop_stall", {31'd0, stall}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("rundrop_quot", quot, 32'd100);
        chk("rundrop_rem", rem, 32'd0);

        // async reset during iteration 10
        x   = 32'd100;
        y   = 32'd7;
        run = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem", rem, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd1);
        #1;
        rst_n = 1'b1;
        #1;
        wait_done(n);
        chk("rst_restart_cycles", n, 33);
        chk("rst_restart_quot", quot, 32'd14);
        chk("rst_restart_rem", rem, 32'd2);
        run = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
